// File: rtl/sli_pattern_gen.sv
// sli_pattern_gen: structured-light fringe generator / video pass-through with frame sequencer and camera trigger.
// Optional `SLI_COLUMN_EN adds an orient input selecting column-indexed fringes.
module sli_pattern_gen #(
    parameter int DATA_W      = 8,
    parameter int LUT_AW      = 10,
    parameter int N_PHASE     = 8,
    parameter int N_FREQ      = 3,
    parameter int ROW_W       = 11,
    parameter int TRIG_CYCLES = 524288,
    localparam int PW = (N_PHASE > 1) ? $clog2(N_PHASE) : 1,
    localparam int FW = (N_FREQ > 1) ? $clog2(N_FREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              rdy,
`ifdef SLI_COLUMN_EN
    input  logic              orient,
`endif
    input  logic              lut_we,
    input  logic [LUT_AW-1:0] lut_addr,
    input  logic [DATA_W-1:0] lut_data,
    input  logic [DATA_W-1:0] in_red,
    input  logic [DATA_W-1:0] in_green,
    input  logic [DATA_W-1:0] in_blue,
    input  logic              in_blank,
    input  logic              in_hsync,
    input  logic              in_vsync,
    output logic [DATA_W-1:0] out_red,
    output logic [DATA_W-1:0] out_green,
    output logic [DATA_W-1:0] out_blue,
    output logic              out_blank,
    output logic              out_hsync,
    output logic              out_vsync,
    output logic              trig,
    output logic              f_frm,
    output logic [PW-1:0]     phase,
    output logic [FW-1:0]     freq
);
    localparam int LUT_DEPTH = 2 ** LUT_AW;
    localparam int STEP      = LUT_DEPTH / N_PHASE;
    localparam int CW        = $clog2(TRIG_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ARMED, EXPOSE} state_t;

    logic [DATA_W-1:0] lut [LUT_DEPTH];
    logic              hs_q, vs_q, hs_rise, vs_rise;
    logic [ROW_W-1:0]  row, pos;
    logic              seen, first_done, hold, first_px, flag;
    logic [DATA_W-1:0] tl;
    logic [PW-1:0]     ph_n;
    logic [FW-1:0]     fr_n;
    logic [LUT_AW-1:0] idx_c, idx_q;
    logic [DATA_W-1:0] r1, g1, b1;
    logic              bl1, hs1, vs1, m1;
    state_t            state;
    logic              pend;
    logic [CW-1:0]     cnt;

    always_comb begin
        hs_rise  = in_hsync & ~hs_q;
        vs_rise  = in_vsync & ~vs_q;
        first_px = ~in_blank & ~first_done;
        flag     = first_px & (mode ? (in_red != tl) : ~hold);
        ph_n     = (phase == PW'(N_PHASE - 1)) ? '0 : phase + 1'b1;
        fr_n     = (phase != PW'(N_PHASE - 1)) ? freq : (freq == FW'(N_FREQ - 1)) ? '0 : freq + 1'b1;
        idx_c    = (LUT_AW'(pos) << freq) + LUT_AW'(int'(phase) * STEP);
    end

`ifdef SLI_COLUMN_EN
    logic [ROW_W-1:0] col;
    logic             orient_q;
    assign pos = orient_q ? col : row;
    always_ff @(posedge clk) begin
        if (rst) begin
            col      <= '0;
            orient_q <= 1'b0;
        end else begin
            col      <= hs_rise ? '0 : (!in_blank && col != '1) ? col + 1'b1 : col;
            orient_q <= vs_rise ? orient : orient_q;
        end
    end
`else
    assign pos = row;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            row        <= '0;
            seen       <= 1'b0;
            first_done <= 1'b0;
            tl         <= '0;
        end else begin
            hs_q       <= in_hsync;
            vs_q       <= in_vsync;
            first_done <= vs_rise ? 1'b0 : first_done | ~in_blank;
            if (first_px && mode)
                tl <= in_red;
            // vsync wins over a coincident hsync: row is cleared, never incremented
            if (vs_rise) begin
                row  <= '0;
                seen <= 1'b0;
            end else if (hs_rise) begin
                row  <= (seen && row != '1) ? row + 1'b1 : row;
                seen <= 1'b0;
            end else if (!in_blank) begin
                seen <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
            freq  <= '0;
            hold  <= 1'b0;
            f_frm <= 1'b1;
        end else if (vs_rise) begin
            hold <= ~rdy;
            if (rdy) begin
                phase <= ph_n;
                freq  <= fr_n;
                f_frm <= (ph_n == '0) && (fr_n == '0);
            end
        end
    end

    always_ff @(posedge clk)
        if (lut_we)
            lut[lut_addr] <= lut_data;

    // stage 2 samples the array before this edge's write lands, giving read-first behaviour
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q     <= '0;
            r1        <= '0;
            g1        <= '0;
            b1        <= '0;
            bl1       <= 1'b1;
            hs1       <= 1'b0;
            vs1       <= 1'b0;
            m1        <= 1'b0;
            out_red   <= '0;
            out_green <= '0;
            out_blue  <= '0;
            out_blank <= 1'b1;
            out_hsync <= 1'b0;
            out_vsync <= 1'b0;
        end else begin
            idx_q     <= idx_c;
            r1        <= in_red;
            g1        <= in_green;
            b1        <= in_blue;
            bl1       <= in_blank;
            hs1       <= in_hsync;
            vs1       <= in_vsync;
            m1        <= mode;
            out_red   <= (!m1 && !bl1) ? lut[idx_q] : r1;
            out_green <= (!m1 && !bl1) ? lut[idx_q] : g1;
            out_blue  <= (!m1 && !bl1) ? lut[idx_q] : b1;
            out_blank <= bl1;
            out_hsync <= hs1;
            out_vsync <= vs1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            trig  <= 1'b0;
            pend  <= 1'b0;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE:   state <= flag ? ARMED : IDLE;
                ARMED: if (vs_rise) begin
                    state <= EXPOSE;
                    trig  <= 1'b1;
                    cnt   <= '0;
                end
                EXPOSE: begin
                    pend <= pend | flag;
                    // a flag seen mid-pulse is kept and re-arms once the pulse completes
                    if (cnt == CW'(TRIG_CYCLES - 1)) begin
                        trig  <= 1'b0;
                        state <= (pend | flag) ? ARMED : IDLE;
                        pend  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sli_pattern_gen.sv
// tb_sli_pattern_gen: directed + randomized frames checked against a frame-level reference model.
module tb_sli_pattern_gen;
    logic       clk = 1'b0;
    logic       rst, mode, rdy, lut_we;
    logic [9:0] lut_addr;
    logic [7:0] lut_data, in_red, in_green, in_blue;
    logic       in_blank, in_hsync, in_vsync;
    logic [7:0] out_red, out_green, out_blue;
    logic       out_blank, out_hsync, out_vsync, trig, f_frm;
    logic [2:0] phase;
    logic [1:0] freq;

    always #5 clk = ~clk;

    sli_pattern_gen #(.TRIG_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .mode(mode), .rdy(rdy),
        .lut_we(lut_we), .lut_addr(lut_addr), .lut_data(lut_data),
        .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
        .in_blank(in_blank), .in_hsync(in_hsync), .in_vsync(in_vsync),
        .out_red(out_red), .out_green(out_green), .out_blue(out_blue),
        .out_blank(out_blank), .out_hsync(out_hsync), .out_vsync(out_vsync),
        .trig(trig), .f_frm(f_frm), .phase(phase), .freq(freq)
    );

    typedef struct packed {logic mark; logic [26:0] vid;} exp_t;
    exp_t       q[$];
    int         errors = 0, checks = 0;
    logic [7:0] lut_m [1024];
    int         ph_m, fr_m, trig_left, trig_cnt;
    bit         hold_m, armed_m, first_m, prev_vs;
    logic [7:0] tl_m, cap;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        ph_m = 0; fr_m = 0; hold_m = 0; armed_m = 0; first_m = 0;
        tl_m = 0; trig_left = 0; prev_vs = 0;
        q.delete();
    endtask

    task automatic idle();
        in_blank = 1'b1; in_hsync = 1'b0; in_vsync = 1'b0;
        in_red = 0; in_green = 0; in_blue = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        @(posedge clk); #1;
        check("rst_trig", trig, 0);
        check("rst_phase", phase, 0);
        check("rst_freq", freq, 0);
        check("rst_ffrm", f_frm, 1);
        check("rst_blank", out_blank, 1);
        check("rst_video", {out_red, out_green, out_blue, out_hsync, out_vsync}, 0);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic load_lut(input bit rnd);
        idle();
        q.delete();
        for (int a = 0; a < 1024; a++) begin
            lut_we = 1'b1; lut_addr = 10'(a);
            lut_data = rnd ? 8'($urandom) : 8'(a);
            lut_m[a] = lut_data;
            @(posedge clk); #1;
        end
        lut_we = 1'b0;
    endtask

    // One pixel clock: the model predicts the output the DUT must show two cycles later and the trigger now.
    task automatic step(input logic bl, input logic hs, input logic vs, input logic [7:0] r, input int row, input bit mark);
        logic [7:0] g, b, v;
        exp_t e;
        g = 8'($urandom); b = 8'($urandom);
        in_blank = bl; in_hsync = hs; in_vsync = vs;
        in_red = r; in_green = g; in_blue = b;
        if (vs && !prev_vs) begin
            if (rdy) begin
                hold_m = 0;
                ph_m = (ph_m + 1) % 8;
                if (ph_m == 0) fr_m = (fr_m + 1) % 3;
            end else hold_m = 1;
            if (armed_m) begin armed_m = 0; trig_left = 16; end
            first_m = 0;
        end
        prev_vs = vs;
        if (!bl && !first_m) begin
            first_m = 1;
            if (mode ? (r != tl_m) : !hold_m) armed_m = 1;
            if (mode) tl_m = r;
        end
        if (!bl && !mode) begin
            v = lut_m[((row << fr_m) + ph_m * 128) % 1024];
            e.vid = {v, v, v, bl, hs, vs};
        end else e.vid = {r, g, b, bl, hs, vs};
        e.mark = mark;
        q.push_back(e);
        @(posedge clk); #1;
        check("trig", trig, trig_left > 0);
        if (trig) trig_cnt++;
        if (trig_left > 0) trig_left--;
        if (q.size() == 2) begin
            check("video", {out_red, out_green, out_blue, out_blank, out_hsync, out_vsync}, q[0].vid);
            if (q[0].mark) cap = out_red;
            void'(q.pop_front());
        end
    endtask

    task automatic frame(input logic [7:0] tl_red);
        step(1'b1, 1'b0, 1'b1, 8'($urandom), 0, 0);
        check("phase", phase, ph_m);
        check("freq", freq, fr_m);
        check("f_frm", f_frm, ph_m == 0 && fr_m == 0);
        step(1'b1, 1'b0, 1'b1, 8'($urandom), 0, 0);
        step(1'b1, 1'b0, 1'b0, 8'($urandom), 0, 0);
        step(1'b1, 1'b1, 1'b0, 8'($urandom), 0, 0);
        step(1'b1, 1'b0, 1'b0, 8'($urandom), 0, 0);
        for (int l = 0; l < 8; l++) begin
            for (int p = 0; p < 4; p++)
                step(1'b0, 1'b0, 1'b0, (l == 0 && p == 0) ? tl_red : 8'($urandom), l, l == 5 && p == 0);
            step(1'b1, 1'b0, 1'b0, 8'($urandom), l, 0);
            step(1'b1, 1'b1, 1'b0, 8'($urandom), l, 0);
            step(1'b1, 1'b0, 1'b0, 8'($urandom), l, 0);
            step(1'b1, 1'b0, 1'b0, 8'($urandom), l, 0);
        end
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; rdy = 1'b1; lut_we = 1'b0; lut_addr = 0; lut_data = 0;
        trig_cnt = 0; cap = 0;
        idle();
        repeat (2) @(posedge clk);
        do_reset();
        load_lut(0);
        frame(0); frame(0);
        check("row5_f0_ph2", cap, 8'h05);
        for (int k = 3; k <= 10; k++) frame(0);
        check("row5_f1_ph2", cap, 8'h0a);
        for (int k = 11; k <= 24; k++) frame(0);
        check("wrap24_freq", freq, 0);
        check("wrap24_ffrm", f_frm, 1);
        rdy = 1'b0; frame(0);
        rdy = 1'b1; trig_cnt = 0; frame(0);
        check("hold_no_trig", trig_cnt, 0);
        trig_cnt = 0; frame(0);
        check("pulse_len", trig_cnt, 16);
        mode = 1'b1; frame(8'h40);
        trig_cnt = 0; frame(8'h40);
        check("tl_warm_pulse", trig_cnt, 16);
        trig_cnt = 0; frame(8'h40);
        check("tl_same_a", trig_cnt, 0);
        trig_cnt = 0; frame(8'h41);
        check("tl_same_b", trig_cnt, 0);
        trig_cnt = 0; frame(8'h41);
        check("tl_change_pulse", trig_cnt, 16);
        load_lut(1);
        for (int k = 0; k < 6; k++) begin
            mode = 1'($urandom);
            rdy = ($urandom % 4) != 0;
            frame(8'h20 + 8'($urandom_range(0, 1)));
        end
        mode = 1'b0; rdy = 1'b1;
        frame(0);
        step(1'b1, 1'b0, 1'b1, 8'($urandom), 0, 0);
        step(1'b1, 1'b0, 1'b1, 8'($urandom), 0, 0);
        step(1'b1, 1'b0, 1'b0, 8'($urandom), 0, 0);
        check("trig_pre_rst", trig, 1);
        do_reset();
        frame(0); frame(0); frame(0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sli_pattern_gen.md
Name: sli_pattern_gen

Overview:
- Parametrised successor to the single-LUT structured-light pixel pipe.
- Sits between the HDMI/DVI decoder and encoder.
- In pattern mode it replaces active video with sinusoidal fringe values from an internal LUT, indexed by row (or column), spatial frequency and phase step. In pass-through mode it forwards video unchanged.
- Sequences phase/frequency frames under a `rdy` handshake and drives a fixed-length camera trigger per new frame.

Parameters:
- DATA_W, 8, bits per colour channel and per LUT entry
- LUT_AW, 10, LUT address width; LUT_DEPTH = 2**LUT_AW entries
- N_PHASE, 8, phase steps per frequency; must divide LUT_DEPTH
- N_FREQ, 3, spatial frequencies; frequency k doubles the fringe rate k times (shift by k)
- ROW_W, 11, row/column counter width
- TRIG_CYCLES, 524288, trigger high time in clk cycles

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- mode  in  1  1 = pass-through, 0 = pattern generation
- rdy  in  1  camera/host ready; sampled at vsync rising edge to advance the sequence
- lut_we  in  1  LUT write strobe
- lut_addr  in  LUT_AW  LUT write address
- lut_data  in  DATA_W  LUT write data
- in_red, in_green, in_blue  in  DATA_W each  input video
- in_blank, in_hsync, in_vsync  in  1 each  input timing, all active-high
- out_red, out_green, out_blue  out  DATA_W each  output video
- out_blank, out_hsync, out_vsync  out  1 each  delayed timing
- trig  out  1  camera exposure trigger
- f_frm  out  1  high while phase==0 and freq==0
- phase  out  clog2(N_PHASE)  current phase index
- freq  out  clog2(N_FREQ)  current frequency index

Behaviour:
- Reset values:
  - out video 0; out_blank 1; out_hsync/out_vsync 0
  - trig 0; phase 0; freq 0; f_frm 1
  - row 0; hold 0; trigger counter 0; top-left register 0
- Edge detection: hsync and vsync rising edges are detected in the clk domain from registered copies. No logic is clocked by sync signals.
- Row counter:
  - Cleared on vsync rise.
  - Incremented on hsync rise only if at least one active pixel (blank=0) occurred since the previous hsync rise.
  - Saturates at 2**ROW_W-1.
- Frame sequencer, on vsync rise:
  - If rdy=1: hold<=0 and phase advances; on wrap N_PHASE-1 -> 0, freq advances; freq wraps N_FREQ-1 -> 0.
  - If rdy=0: hold<=1, phase and freq unchanged.
- Index: idx = ((pos << freq) + phase*(LUT_DEPTH/N_PHASE)) mod LUT_DEPTH, where pos = row by default. Truncation to LUT_AW bits gives the modulo.
- Pipeline:
  - 2-cycle latency for video, blank and syncs, all delayed equally.
  - Stage 1 registers idx and the video/timing inputs.
  - Stage 2 registers the LUT read and the output mux.
  - Pattern mode: active pixel -> LUT value on all three channels; blanked pixel -> delayed input.
  - Pass-through mode: delayed input always.
- LUT write port: single-port write, read-first. A same-address read/write in one cycle returns the old data. Writes are accepted in any mode.
- Frame flag is evaluated at the first active pixel of each frame (top-left, TL):
  - Pattern mode: flag = !hold.
  - Pass-through mode: flag = (in_red != stored TL). TL register is updated with in_red.
- Trigger FSM, states IDLE -> ARMED -> EXPOSE:
  - IDLE -> ARMED when flag is set.
  - ARMED -> EXPOSE on the next vsync rise; trig goes high the following cycle.
  - EXPOSE holds trig high for exactly TRIG_CYCLES cycles, then returns to IDLE.
  - A flag arriving during EXPOSE re-arms (ARMED pending). The current pulse is not truncated; the next pulse starts at the following vsync rise.
- Mid-operation reset: all of the above return to reset values within one cycle. LUT contents are preserved.
- Simultaneous vsync and hsync rise: vsync takes priority; row is cleared, not incremented.

Optional Feature:
- Macro: SLI_COLUMN_EN.
- Defined:
  - Adds input `orient` (1 bit) and an internal column counter, ROW_W wide, cleared on hsync rise and incremented per active pixel.
  - pos = orient ? column : row.
  - orient is sampled only at vsync rise, so a frame never mixes orientations.
- Undefined: no orient port, no column counter; pos = row.

Test Plan:
- LUT[a]=a[7:0] loaded, mode=0, rdy=1 for two frames (freq=0, phase=2) -> row 5 active pixels output 0x05+0x00? check: idx=5+2*128=261 -> outputs 0x05 on all channels, two cycles after input.
- Same LUT, freq=1, phase=2, row 5 -> idx=266 -> out 0x0A. Blanked pixels pass input through unchanged.
- rdy=1 for 8 vsyncs from reset -> phase 0..7 then wraps, freq 0->1. After 24 vsyncs freq back to 0 and f_frm=1.
- rdy=0 at a vsync -> phase/freq held, hold=1, no trig for that frame. rdy=1 next vsync -> trig pulse of exactly TRIG_CYCLES (use TRIG_CYCLES=16 in bench).
- mode=1, TL red 0x40 then 0x40 then 0x41 across three frames -> only the third frame arms, with trig following the next vsync rise. Video equals input delayed 2 cycles.
- rst asserted mid-EXPOSE -> trig 0 next cycle, phase/freq 0. LUT readback is unchanged afterwards.
